booth_r4_seq_mult: RTL

Iterative radix-4 Booth multiplier, parametrised in operand width, with per-operand signed/unsigned mode. Generates one Booth partial product per clock and accumulates it into a 2*WIDTH product register, trading latency for area versus a full partial-product array. Sits in the datapath wherever a multi-cycle multiply is acceptable. Uses valid/ready handshakes on both input and output.

---
 rtl/booth_pkg.sv | 23 ++
 rtl/booth_r4_pp_sel.sv | 43 ++++
 rtl/booth_r4_seq_mult.sv | 115 +++++++++++
 3 files changed

// File: rtl/booth_pkg.sv
// Shared types for the radix-4 Booth sequential multiplier.
// Booth digit selects, FSM states, partial-product count helper.
package booth_pkg;

    typedef enum logic [2:0] {
        SEL_ZERO,
        SEL_POS1,
        SEL_POS2,
        SEL_NEG1,
        SEL_NEG2
    } booth_sel_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    function automatic int npp(input int width);
        return width / 2 + 1;
    endfunction

endpackage

// File: rtl/booth_r4_pp_sel.sv
// Radix-4 Booth partial-product generator (combinational).
// Ports: trip (3-bit Booth triplet), x (WIDTH+2 sign-extended
// multiplicand), pp (WIDTH+3 signed partial product).
module booth_r4_pp_sel
    import booth_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [2:0]       trip,
    input  logic [WIDTH+1:0] x,
    output logic [WIDTH+2:0] pp
);

    booth_sel_t       sel;
    logic [WIDTH+2:0] x1;
    logic [WIDTH+2:0] x2;

    assign x1 = {x[WIDTH+1], x};
    assign x2 = {x, 1'b0};

    always_comb begin
        sel = SEL_ZERO;
        unique case (trip)
            3'b001, 3'b010: sel = SEL_POS1;
            3'b011:         sel = SEL_POS2;
            3'b100:         sel = SEL_NEG2;
            3'b101, 3'b110: sel = SEL_NEG1;
            default:        sel = SEL_ZERO;
        endcase
    end

    always_comb begin
        pp = '0;
        unique case (sel)
            SEL_POS1: pp = x1;
            SEL_POS2: pp = x2;
            SEL_NEG1: pp = -x1;
            SEL_NEG2: pp = -x2;
            default:  pp = '0;
        endcase
    end

endmodule

// File: rtl/booth_r4_seq_mult.sv
// Iterative radix-4 Booth multiplier, one partial product per clock.
// Ports: i_clk, i_rst_n, i_valid/o_ready (operand handshake),
// i_multa_ns/i_multb_ns (1=signed), i_multa, i_multb,
// o_valid/i_ready (result handshake), o_product, o_busy.
// Optional BOOTH_MAC_EN adds i_addend, preloaded into the accumulator.
module booth_r4_seq_mult
    import booth_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic               i_multa_ns,
    input  logic               i_multb_ns,
    input  logic [WIDTH-1:0]   i_multa,
    input  logic [WIDTH-1:0]   i_multb,
`ifdef BOOTH_MAC_EN
    input  logic [2*WIDTH-1:0] i_addend,
`endif
    output logic               o_valid,
    input  logic               i_ready,
    output logic [2*WIDTH-1:0] o_product,
    output logic               o_busy
);

    localparam int NPP = npp(WIDTH);
    localparam int CW  = $clog2(NPP + 1);
    localparam int PW  = WIDTH + 3;
    localparam int AW  = 2 * WIDTH;

    state_t           state_q;
    state_t           state_d;
    logic [CW-1:0]    ctr_q;
    logic [WIDTH+1:0] x_q;
    logic [WIDTH+2:0] y_q;
    logic [AW-1:0]    acc_q;
    logic [AW-1:0]    pp_q;
    logic [PW-1:0]    pp;
    logic [AW-1:0]    pp_ext;
    logic [AW-1:0]    pp_sh;
    logic [AW-1:0]    preload;
    logic             accept;
    logic             last;

    booth_r4_pp_sel #(
        .WIDTH (WIDTH)
    ) u_pp_sel (
        .trip (y_q[2:0]),
        .x    (x_q),
        .pp   (pp)
    );

    assign pp_ext = {{(AW - PW){pp[PW-1]}}, pp};
    assign pp_sh  = pp_ext << {ctr_q, 1'b0};

`ifdef BOOTH_MAC_EN
    assign preload = i_addend;
`else
    assign preload = '0;
`endif

    assign o_ready   = (state_q == IDLE) ||
                       (state_q == DONE && i_ready);
    assign accept    = i_valid && o_ready;
    assign o_valid   = (state_q == DONE);
    assign o_busy    = (state_q == CALC);
    assign o_product = acc_q;

    // The shifted partial product is registered before the add, so
    // CALC spends one extra cycle draining the last product.
    assign last = (ctr_q == CW'(NPP));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = CALC;
            CALC: if (last) state_d = DONE;
            DONE: begin
                if (accept)       state_d = CALC;
                else if (i_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ctr_q <= '0;
            x_q   <= '0;
            y_q   <= '0;
            acc_q <= '0;
            pp_q  <= '0;
        end else if (accept) begin
            ctr_q <= '0;
            x_q   <= {{2{i_multa_ns & i_multa[WIDTH-1]}}, i_multa};
            y_q   <= {{2{i_multb_ns & i_multb[WIDTH-1]}},
                      i_multb, 1'b0};
            acc_q <= preload;
            pp_q  <= '0;
        end else if (state_q == CALC) begin
            ctr_q <= ctr_q + CW'(1);
            y_q   <= {2'b00, y_q[WIDTH+2:2]};
            pp_q  <= pp_sh;
            acc_q <= acc_q + pp_q;
        end
    end

endmodule
